// File: rtl/demux_rr_dispatch.sv
// Round-robin burst dispatcher: steers one valid/ready stream across four
// demux channels in bursts of up to BURST_LEN beats, skipping disabled channels.
module demux_rr_dispatch #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        chan_en_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [3:0]        out_valid_o,
    input  logic [3:0]        out_ready_i,
    output logic [1:0]        sel_o,
    output logic              burst_done_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             burst_done_q, burst_done_d;

    logic             grant_vld;
    logic [1:0]       grant_ch;
    logic [1:0]       cand;
    logic             xfer_beat;
    logic             burst_end;

    // Round-robin search ptr+1..ptr+4; iterating backwards lets the nearest hit win.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = 2'd0;
        cand      = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            cand = ptr_q + 2'(i);
            if (chan_en_i[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
    end

    assign xfer_beat = (state_q == XFER) && in_valid_i && out_ready_i[sel_q];
    assign burst_end = (cnt_q == CNT_W'(BURST_LEN - 1)) || in_last_i;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        burst_done_d = 1'b0;
        in_ready_o   = 1'b0;
        out_valid_o  = 4'b0000;

        case (state_q)
            IDLE: begin
                if (in_valid_i && grant_vld) begin
                    sel_d   = grant_ch;
                    ptr_d   = grant_ch;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                in_ready_o         = out_ready_i[sel_q];
                out_valid_o[sel_q] = in_valid_i;
                if (xfer_beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (burst_end) begin
                        state_d      = IDLE;
                        burst_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            ptr_q        <= 2'd3;
            sel_q        <= 2'd0;
            cnt_q        <= '0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign out_data_o   = in_data_i;
    assign sel_o        = sel_q;
    assign burst_done_o = burst_done_q;
    assign busy_o       = (state_q == XFER);

endmodule

// File: doc/demux_rr_dispatch.md
Name: demux_rr_dispatch

Overview:
- Round-robin scheduler that drives the select of a 1-to-4 demultiplexer datapath.
- Distributes a single valid/ready input stream across four output channels in bursts of BURST_LEN beats.
- Skips channels that are disabled by configuration.
- Sits between a single producer and four downstream consumers; provides the registered select and per-channel handshake steering.

Parameters:
- DATA_W, 8, width of the data bus.
- BURST_LEN, 4, maximum beats forwarded to one channel per grant (legal range 1..256).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- chan_en  input  4  per-channel enable; bit k enables channel k
- in_data  input  DATA_W  input stream data
- in_valid  input  1  input beat valid
- in_last  input  1  marks the final beat of a packet; ends the burst early
- in_ready  output  1  input beat accepted when in_valid && in_ready
- out_data  output  DATA_W  data to all channels; equals in_data (combinational)
- out_valid  output  4  one-hot valid; only the granted channel's bit can be high
- out_ready  input  4  per-channel ready
- sel  output  2  registered channel select (demux select)
- burst_done  output  1  one-cycle pulse after the final beat of a burst
- busy  output  1  high while in XFER state

Behaviour:
- Reset values (asynchronous): state=IDLE, ptr=3, sel=0, cnt=0, burst_done=0, in_ready=0, out_valid=0, busy=0.
- ptr holds the last granted channel. ptr=3 at reset, so the first grant goes to the lowest enabled channel at or after 0.
- IDLE state:
  - in_ready=0 and out_valid=0.
  - If in_valid && |chan_en: pick the first enabled channel in search order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Load sel and ptr with the chosen channel, clear cnt, go to XFER.
  - Otherwise remain in IDLE.
  - Arbitration costs exactly one cycle: the first beat of any burst is accepted no earlier than the cycle after in_valid is seen in IDLE.
- XFER state:
  - in_ready = out_ready[sel].
  - out_valid[k] = in_valid && (k==sel); all other bits are 0.
  - out_data = in_data.
  - A beat transfers when in_valid && out_ready[sel]. Each transfer increments cnt.
  - The burst ends on the transferring beat when cnt==BURST_LEN-1 or in_last=1.
  - At burst end: state goes to IDLE and burst_done=1 for the next cycle only.
  - No transfer: hold state, cnt and sel. Stalls of any length are legal.
- chan_en is sampled only during arbitration.
  - Deasserting chan_en[sel] mid-burst does not abort the burst; it completes normally.
  - chan_en=0 in IDLE: stay in IDLE, in_ready=0, so the input stalls.
- in_valid dropping mid-burst: no transfers occur; state and counter are held.
- in_last and the cnt limit on the same beat: a single burst end, a single burst_done pulse.
- Single enabled channel: it is re-granted every burst, with the 1-cycle IDLE gap between bursts.
- busy = (state==XFER).
- sel changes only in IDLE→XFER transitions. It never changes while any out_valid bit is high.
- Reset asserted mid-burst: all state returns to reset values immediately. The beat in flight is not accepted.
- Throughput: BURST_LEN beats per BURST_LEN+1 cycles with continuous valid/ready.

Test Plan:
- Reset, chan_en=4'b1111, continuous in_valid with data 0x00.., all out_ready=1, BURST_LEN=4, in_last=0 → beats 0x00–0x03 on ch0, 0x04–0x07 on ch1, 0x08–0x0B on ch2, 0x0C–0x0F on ch3, then ch0 again. One idle cycle before each burst; burst_done pulses after beats 0x03, 0x07, 0x0B, 0x0F.
- chan_en=4'b1010 → grants alternate ch1, ch3, ch1. out_valid[0] and out_valid[2] are never high.
- Burst on ch2, out_ready[2]=0 for 5 cycles after beat 2 → in_ready=0; cnt and sel stay at 2; beats resume in order and exactly 4 beats reach ch2.
- in_last=1 on the 2nd beat of a burst to ch0 → burst ends after 2 beats, burst_done pulses once, next grant is ch1.
- chan_en changes from 4'b0001 to 4'b0000 mid-burst → the current burst completes on ch0. The FSM then stays in IDLE with in_ready=0 until chan_en is re-enabled.
- rst pulsed mid-burst on ch1 → out_valid=0, in_ready=0, sel=0, busy=0 immediately. After release, the first grant is ch0.
